// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule expander: loads one 512-bit padded block and
// streams W[0..ROUNDS-1] over a valid/ready handshake, one word per beat.
// Optional feature: define MSG_SCHED_ABORT_EN to add the 'abort' input.
module sha256_msg_sched #(
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned IDX_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef MSG_SCHED_ABORT_EN
    input  logic             abort,
`endif
    input  logic [511:0]     block_in,
    output logic             busy,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [31:0]      w_out,
    output logic [IDX_W-1:0] w_idx,
    output logic             done
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(ROUNDS - 1);

    // Small sigma0: ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [31:0] s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // Small sigma1: ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [31:0] s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] t_q, t_d;
    logic [31:0]      r_q [16];
    logic [31:0]      r_d [16];
    logic             abort_req;
    logic [31:0]      w_new;

`ifdef MSG_SCHED_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Next schedule word W[t+16], computed from the current window (r[0] = W[t])
    assign w_new = s1(r_q[14]) + r_q[9] + s0(r_q[1]) + r_q[0];

    // Next-state: block load, window shift on handshake, abort, and DONE return
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        r_d     = r_q;
        case (state_q)
            StIdle: begin
                // abort in IDLE swallows a simultaneous start
                if (start && !abort_req) begin
                    for (int i = 0; i < 16; i++) begin
                        r_d[i] = block_in[511 - 32*i -: 32];
                    end
                    t_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort_req) begin
                    state_d = StIdle;
                end else if (w_ready) begin
                    if (t_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        for (int i = 0; i < 15; i++) begin
                            r_d[i] = r_q[i+1];
                        end
                        r_d[15] = w_new;
                        t_d     = t_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, index and window registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            t_q     <= '0;
            for (int i = 0; i < 16; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            for (int i = 0; i < 16; i++) begin
                r_q[i] <= r_d[i];
            end
        end
    end

    // Outputs come straight from flops; w_out never passes through the adders
    always_comb begin
        busy    = (state_q != StIdle);
        w_valid = (state_q == StRun);
        done    = (state_q == StDone);
        w_out   = r_q[0];
        w_idx   = t_q;
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for sha256_msg_sched: directed block sequence with random data and
// random back-pressure, checked against a plain-arithmetic schedule model.
module tb_sha256_msg_sched;

    localparam int ROUNDS = 64;
    localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         w_ready = 1'b0;
    logic [511:0] block_in = '0;
    logic         busy, w_valid, done;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;
`ifdef MSG_SCHED_ABORT_EN
    logic         abort = 1'b0;
`endif

    int checks = 0;
    int passes = 0;
    logic [31:0] exp_w [ROUNDS];

    sha256_msg_sched #(
        .ROUNDS (ROUNDS),
        .IDX_W  (6)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef MSG_SCHED_ABORT_EN
        .abort    (abort),
`endif
        .block_in (block_in),
        .busy     (busy),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_out    (w_out),
        .w_idx    (w_idx),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x};
        return d[n +: 32];
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Full message schedule W[0..63] from the textbook recurrence
    task automatic build_model(input logic [511:0] b);
        for (int t = 0; t < ROUNDS; t++) begin
            if (t < 16) exp_w[t] = b[511 - 32*t -: 32];
            else exp_w[t] = sig1(exp_w[t-2]) + exp_w[t-7] + sig0(exp_w[t-15]) + exp_w[t-16];
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Entered and left on a negedge. Starts one block and consumes it.
    task automatic run_block(input logic [511:0] blk, input bit rand_rdy, input bit scramble,
                             input bit poke, input int rst_at, input int abort_at);
        int  idx;
        int  cyc;
        bit  rdy;
        build_model(blk);
        start    = 1'b1;
        block_in = blk;
        @(negedge clk);
        start = 1'b0;
        if (scramble) block_in = rand_block();
        check("valid_after_start", w_valid, 1);
        idx = 0;
        cyc = 0;
        while (idx < ROUNDS && cyc < 600) begin
            check("w_valid", w_valid, 1);
            check("busy_run", busy, 1);
            check("no_early_done", done, 0);
            check("w_idx", w_idx, idx);
            check("w_out", w_out, exp_w[idx]);
            if (blk == ABC && idx == 16) check("abc_w16", w_out, 32'h61626380);
            if (blk == ABC && idx == 17) check("abc_w17", w_out, 32'h000F0000);
            if (idx == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_valid", w_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_w_out", w_out, 0);
                check("rst_w_idx", w_idx, 0);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check("post_rst_valid", w_valid, 0);
                check("post_rst_done", done, 0);
                return;
            end
`ifdef MSG_SCHED_ABORT_EN
            if (idx == abort_at) begin
                abort   = 1'b1;
                w_ready = 1'b1;
                @(negedge clk);
                abort   = 1'b0;
                w_ready = 1'b0;
                check("abort_valid", w_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_idx_le", (w_idx <= 6'(abort_at)), 1);
                @(negedge clk);
                check("abort_no_done", done, 0);
                return;
            end
`endif
            rdy      = rand_rdy ? bit'($urandom_range(1, 0)) : 1'b1;
            w_ready  = rdy;
            start    = poke && (idx == 5);
            if (scramble) block_in = rand_block();
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (rdy) idx++;
        end
        check("words_streamed", idx, ROUNDS);
        w_ready = $urandom_range(1, 0);
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_valid", w_valid, 0);
        if (poke) begin
            start    = 1'b1;
            block_in = rand_block();
        end
        @(negedge clk);
        start = 1'b0;
        check("after_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_valid", w_valid, 0);
        w_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_valid", w_valid, 0);
        check("reset_done", done, 0);
        check("reset_w_out", w_out, 0);
        check("reset_w_idx", w_idx, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_valid", w_valid, 0);

        // "abc" block, full throughput then random back-pressure
        run_block(ABC, 1'b0, 1'b0, 1'b0, -1, -1);
        run_block(ABC, 1'b1, 1'b0, 1'b0, -1, -1);

        // start in RUN and in DONE ignored; restart 1 cycle after done
        run_block(rand_block(), 1'b1, 1'b0, 1'b1, -1, -1);
        run_block(rand_block(), 1'b0, 1'b0, 1'b0, -1, -1);

        // block_in changing every cycle after capture
        run_block(rand_block(), 1'b1, 1'b1, 1'b0, -1, -1);

        // Reset mid-block, then a clean block
        run_block(rand_block(), 1'b0, 1'b0, 1'b0, 30, -1);
        run_block(rand_block(), 1'b1, 1'b0, 1'b0, -1, -1);

`ifdef MSG_SCHED_ABORT_EN
        run_block(rand_block(), 1'b0, 1'b0, 1'b0, -1, 10);
        run_block(rand_block(), 1'b1, 1'b0, 1'b0, -1, -1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
